// File: rtl/key_entry_pkg.sv
// Shared constants for the keypad entry buffer and its multiplexed display.
package key_entry_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_CLR  = 4'hE;
    localparam logic [DIGIT_W-1:0] KEY_BKSP = 4'hF;

    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/digit_refresh_mux.sv
// Free-running digit scan: refresh counter, digit index and blanked
// active-low one-hot digit enables.
module digit_refresh_mux
    import key_entry_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [count_w(NUM_DIGITS)-1:0] count,
    output logic [$clog2(NUM_DIGITS)-1:0]  idx,
    output logic [NUM_DIGITS-1:0]          an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [RW-1:0]         ref_cnt;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  lit;

    assign wrap = (ref_cnt == RW'(REFRESH_DIV - 1));
    // Positions at or above count are leading blanks.
    assign lit  = (int'(idx) < int'(count));

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_cnt <= '0;
            idx     <= '0;
            an      <= '1;
        end else begin
            ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
            if (wrap) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            an <= lit ? ~onehot : '1;
        end
    end

endmodule

// File: rtl/key_entry_display.sv
// Keypad digit buffer with clear/backspace editing, scanned onto a
// common-segment multi-digit display.
module key_entry_display
    import key_entry_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DIGIT_W-1:0]             code,
    input  logic                           reg_load,
    output logic [DIGIT_W-1:0]             seg_code,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [count_w(NUM_DIGITS)-1:0] count,
    output logic                           full
);

    localparam int CW = count_w(NUM_DIGITS);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] d;
    logic                               reg_load_d;
    logic                               load_evt;
    logic [IW-1:0]                      idx;

    // A held strobe counts once: only its rising edge is an event.
    assign load_evt = reg_load & ~reg_load_d;
    assign full     = (count == CW'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (!reset) begin
            d          <= '0;
            count      <= '0;
            reg_load_d <= 1'b0;
            seg_code   <= '0;
        end else begin
            reg_load_d <= reg_load;
            seg_code   <= d[idx];
            if (load_evt) begin
                unique case (1'b1)
                    (code == KEY_CLR): begin
                        d     <= '0;
                        count <= '0;
                    end
                    (code == KEY_BKSP): begin
                        if (count != '0) begin
                            d     <= {DIGIT_W'(0), d[NUM_DIGITS-1:1]};
                            count <= count - 1'b1;
                        end
                    end
                    default: begin
                        d <= {d[NUM_DIGITS-2:0], code};
                        if (!full) begin
                            count <= count + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    digit_refresh_mux #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .idx   (idx),
        .an    (an)
    );

endmodule

// File: tb/tb_key_entry_display.sv
// Directed bench for key_entry_display: entry, scroll, backspace, clear,
// refresh-wrap coincidence and reset priority.
module tb_key_entry_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code;
    logic       reg_load;
    logic [3:0] seg_code;
    logic [3:0] an;
    logic [2:0] count;
    logic       full;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_entry_display #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .code     (code),
        .reg_load (reg_load),
        .seg_code (seg_code),
        .an       (an),
        .count    (count),
        .full     (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        code     = k;
        reg_load = 1'b1;
        repeat (5) @(negedge clk);
        reg_load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int pos_of(input logic [3:0] a);
        logic [3:0] m;
        int p;
        p = -1;
        for (int i = 0; i < 4; i++) begin
            m = 4'b0001 << i;
            if (a === ~m) p = i;
        end
        return p;
    endfunction

    // Watch the scan; every lit position must be a valid digit showing
    // its expected value, and every valid position must light up.
    task automatic check_frame(input string tag, input logic [15:0] exp_d,
                               input int exp_cnt, input int cycles);
        logic [3:0] seen;
        int p;
        seen = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (an !== 4'hF) begin
                p = pos_of(an);
                chk({tag, "_pos"}, (p >= 0 && p < exp_cnt), 1);
                if (p >= 0) begin
                    seen[p] = 1'b1;
                    chk({tag, "_seg"}, seg_code, exp_d[p*4 +: 4]);
                end
            end
        end
        chk({tag, "_seen"}, seen, (1 << exp_cnt) - 1);
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_an;
        logic       found;
        logic       ok;
        int         nxt;
        logic [15:0] wrap_d;

        reset    = 1'b0;
        code     = 4'h0;
        reg_load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg_code, 4'h0);
        chk("rst_count", count, 3'd0);
        chk("rst_full", full, 1'b0);
        check_frame("dark", 16'h0000, 0, 100);

        press(4'h1);
        press(4'h2);
        press(4'h3);
        chk("k123_count", count, 3'd3);
        chk("k123_full", full, 1'b0);
        check_frame("k123", 16'h0123, 3, 40);

        press(4'hE);
        chk("clr_count", count, 3'd0);
        for (int k = 1; k <= 5; k++) press(4'(k));
        chk("k5_count", count, 3'd4);
        chk("k5_full", full, 1'b1);
        check_frame("k5", 16'h2345, 4, 40);

        press(4'hF);
        chk("bs1_count", count, 3'd3);
        chk("bs1_full", full, 1'b0);
        check_frame("bs1", 16'h0234, 3, 40);
        repeat (4) press(4'hF);
        chk("bs4_count", count, 3'd0);
        chk("bs4_full", full, 1'b0);
        check_frame("bs4", 16'h0000, 0, 40);

        for (int k = 1; k <= 4; k++) press(4'(k));
        chk("k1234_count", count, 3'd4);

        // Align to a digit change, then land the key event on the next wrap.
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (an !== prev) found = 1'b1;
        end
        chk("wrap_sync", found, 1'b1);
        prev = an;
        repeat (8) @(negedge clk);
        code     = 4'h9;
        reg_load = 1'b1;
        @(negedge clk);
        chk("wrap_hold", an, prev);
        @(negedge clk);
        wrap_d = 16'h2349;
        nxt    = (pos_of(prev) + 1) % 4;
        exp_an = ~(4'b0001 << nxt);
        chk("wrap_an", an, exp_an);
        chk("wrap_seg", seg_code, wrap_d[nxt*4 +: 4]);
        reg_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap_count", count, 3'd4);
        check_frame("wrap", wrap_d, 4, 40);

        code     = 4'hE;
        reg_load = 1'b1;
        @(negedge clk);
        chk("clr4_count", count, 3'd0);
        chk("clr4_full", full, 1'b0);
        @(negedge clk);
        chk("clr4_an", an, 4'hF);
        reg_load = 1'b0;
        @(negedge clk);

        code     = 4'h7;
        reg_load = 1'b1;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        reg_load = 1'b0;
        @(negedge clk);
        chk("rstk_count", count, 3'd0);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (seg_code !== 4'h0 || an !== 4'hF) ok = 1'b0;
        end
        chk("rstk_dark", ok, 1'b1);
        chk("rstk_count2", count, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
